// File: rtl/encoder_8b10b_mlane.sv
// rtl/encoder_8b10b_mlane.sv - multi-lane two-stage 8b/10b encoder with per-lane running disparity
module encoder_8b10b_mlane #(
  parameter int         LANES     = 2,
  parameter logic [7:0] IDLE_CHAR = 8'hBC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idle_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_k,
  input  logic [8*LANES-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_k_err,
  output logic [LANES-1:0]      out_rd
);

  // Returns {rd_after, abcdei, fghj}; k must already be qualified as a legal K code.
  function automatic logic [10:0] enc_sym(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd6;
    logic       rd4;
    x = b[4:0];
    y = b[7:5];
    case (x)
      5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;  5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
      5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;  5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
      5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;  5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
      5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;  5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
      5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;  5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
      5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;  5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
      5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;  5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
      5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;  5'd30: c6 = 6'b011110;
      default: c6 = 6'b101011;
    endcase
    if (k && x == 5'd28)
      c6 = 6'b001111;
    // D.7 is balanced but still has an RD+ form, like D.x.3 below.
    if (rd && ($countones(c6) != 3 || c6 == 6'b111000))
      c6 = ~c6;
    rd6 = rd ^ ($countones(c6) != 3);
    if (k) begin
      case (y)
        3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b0110;  3'd2: c4 = 4'b1010;  3'd3: c4 = 4'b1100;
        3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b0101;  3'd6: c4 = 4'b1001;
        default: c4 = 4'b0111;
      endcase
      if (rd6)
        c4 = ~c4;
    end else begin
      case (y)
        3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b1001;  3'd2: c4 = 4'b0101;  3'd3: c4 = 4'b1100;
        3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b1010;  3'd6: c4 = 4'b0110;
        default: c4 = ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                       (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14))) ? 4'b0111 : 4'b1110;
      endcase
      if (rd6 && ($countones(c4) != 2 || c4 == 4'b1100))
        c4 = ~c4;
    end
    rd4 = rd6 ^ ($countones(c4) != 2);
    return {rd4, c6, c4};
  endfunction

  logic                 run;
  logic                 s1_full;
  logic [8*LANES-1:0]   s1_data;
  logic [LANES-1:0]     s1_k;
  logic [LANES-1:0]     s1_kerr;
  logic [LANES-1:0]     legal_k;
  logic [10*LANES-1:0]  enc_data;
  logic [LANES-1:0]     enc_rd;
  logic                 s2_adv;
  logic                 accept;

  assign s2_adv   = ~out_valid | out_ready;
  assign in_ready = run & (~s1_full | s2_adv);
  assign accept   = in_valid & in_ready;

  always_comb begin
    legal_k = '0;
    for (int n = 0; n < LANES; n++)
      legal_k[n] = (in_data[8*n +: 5] == 5'd28) ||
                   (in_data[8*n+5 +: 3] == 3'd7 &&
                    (in_data[8*n +: 5] == 5'd23 || in_data[8*n +: 5] == 5'd27 ||
                     in_data[8*n +: 5] == 5'd29 || in_data[8*n +: 5] == 5'd30));
  end

  // S2 encodes either the S1 beat or an idle comma, always from the lane's committed RD.
  always_comb begin
    enc_data = '0;
    enc_rd   = '0;
    for (int n = 0; n < LANES; n++)
      {enc_rd[n], enc_data[10*n +: 10]} = enc_sym(s1_full ? s1_data[8*n +: 8] : IDLE_CHAR,
                                                  s1_full ? s1_k[n] : 1'b1, out_rd[n]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run       <= 1'b0;
      s1_full   <= 1'b0;
      s1_data   <= '0;
      s1_k      <= '0;
      s1_kerr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_k_err <= '0;
      out_rd    <= '0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        s1_full <= 1'b1;
        s1_data <= in_data;
        s1_k    <= in_k & legal_k;
        s1_kerr <= in_k & ~legal_k;
      end else if (s2_adv) begin
        s1_full <= 1'b0;
      end
      if (s2_adv) begin
        if (s1_full || (idle_en && !in_valid)) begin
          out_valid <= 1'b1;
          out_data  <= enc_data;
          out_rd    <= enc_rd;
          out_k_err <= s1_full ? s1_kerr : '0;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder_8b10b_mlane.sv
// tb/tb_encoder_8b10b_mlane.sv - directed bench for the two-lane 8b/10b encoder
module tb_encoder_8b10b_mlane;

  localparam logic [9:0] D00_N  = 10'b1001110100;
  localparam logic [9:0] D00_P  = 10'b0110001011;
  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;
  localparam logic [9:0] K287_N = 10'b0011111000;
  localparam logic [9:0] D215   = 10'b1010101010;
  localparam logic [9:0] D10_N  = 10'b0111010100;

  logic        clk = 1'b0;
  logic        rst;
  logic        idle_en;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_k;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic [1:0]  out_k_err;
  logic [1:0]  out_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  encoder_8b10b_mlane #(.LANES(2), .IDLE_CHAR(8'hBC)) dut (
    .clk(clk), .rst(rst), .idle_en(idle_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_k_err(out_k_err), .out_rd(out_rd)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; idle_en = 1'b0; in_valid = 1'b0; in_k = '0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_en = 1'b0; in_valid = 1'b0; in_k = '0; in_data = '0; out_ready = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 20'h0 || out_rd !== 2'b00 || out_k_err !== 2'b00 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: got v=%b d=%h rd=%b ke=%b rdy=%b, want all zero", out_valid, out_data, out_rd, out_k_err, in_ready);
    end
    @(negedge clk);
    rst = 1'b0; idle_en = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_prestream: out_valid=%b want 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 20'h0 || out_rd !== 2'b00 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got v=%b d=%h rd=%b rdy=%b, want all zero", out_valid, out_data, out_rd, in_ready);
    end
    idle_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_noclk: in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_clk: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_d0();
    apply_reset();
    in_valid = 1'b1; in_k = 2'b00; in_data = 16'h0000;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL d0_latency: out_valid=%b want 0 after 1 clk", out_valid);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== {D00_N, D00_N} || out_rd !== 2'b00 || out_k_err !== 2'b00) begin
      bad++;
      $display("FAIL d0_beat: v=%b d=%b rd=%b ke=%b want 1 %b 00 00", out_valid, out_data, out_rd, out_k_err, {D00_N, D00_N});
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== {D00_N, D00_N}) begin
      bad++;
      $display("FAIL d0_drain: v=%b d=%b want 0 %b", out_valid, out_data, {D00_N, D00_N});
    end
  endtask

  task automatic test_k28();
    logic [19:0] exp_d  [3];
    logic [1:0]  exp_rd [3];
    exp_d[0] = {D215, K285_N}; exp_rd[0] = 2'b01;
    exp_d[1] = {D215, K285_P}; exp_rd[1] = 2'b00;
    exp_d[2] = {D215, K285_N}; exp_rd[2] = 2'b01;
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      if (n < 3) begin
        in_valid = 1'b1; in_k = 2'b01; in_data = 16'hB5BC;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (n >= 1) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_d[n-1] || out_rd !== exp_rd[n-1]) begin
          bad++;
          $display("FAIL k28_beat%0d: v=%b d=%b rd=%b want 1 %b %b", n-1, out_valid, out_data, out_rd, exp_d[n-1], exp_rd[n-1]);
        end
      end
    end
  endtask

  task automatic test_kerr();
    logic [1:0]  stim_k  [3];
    logic [15:0] stim_d  [3];
    logic [19:0] exp_d   [3];
    logic [1:0]  exp_rd  [3];
    logic [1:0]  exp_ke  [3];
    stim_k[0] = 2'b01; stim_d[0] = 16'hB500; exp_d[0] = {D215, D00_N};   exp_rd[0] = 2'b00; exp_ke[0] = 2'b01;
    stim_k[1] = 2'b11; stim_d[1] = 16'hFCBC; exp_d[1] = {K287_N, K285_N}; exp_rd[1] = 2'b01; exp_ke[1] = 2'b00;
    stim_k[2] = 2'b10; stim_d[2] = 16'h0100; exp_d[2] = {D10_N, D00_P};  exp_rd[2] = 2'b01; exp_ke[2] = 2'b10;
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      if (n < 3) begin
        in_valid = 1'b1; in_k = stim_k[n]; in_data = stim_d[n];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (n >= 1) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_d[n-1] || out_rd !== exp_rd[n-1] || out_k_err !== exp_ke[n-1]) begin
          bad++;
          $display("FAIL kerr_beat%0d: v=%b d=%b rd=%b ke=%b want 1 %b %b %b", n-1, out_valid, out_data,
                   out_rd, out_k_err, exp_d[n-1], exp_rd[n-1], exp_ke[n-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_k = 2'b00; in_data = 16'h0000;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_second_accept: in_ready=%b want 1", in_ready);
    end
    in_k = 2'b11; in_data = 16'hBCBC;
    @(negedge clk);
    in_k = 2'b00; in_data = 16'h0000;
    for (int n = 0; n < 5; n++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== {D00_N, D00_N} || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d: v=%b d=%b rdy=%b want 1 %b 0", n, out_valid, out_data, in_ready, {D00_N, D00_N});
      end
      if (n < 4) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== {K285_N, K285_N} || out_rd !== 2'b11) begin
      bad++;
      $display("FAIL stall_release1: v=%b d=%b rd=%b want 1 %b 11", out_valid, out_data, out_rd, {K285_N, K285_N});
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== {D00_P, D00_P} || out_rd !== 2'b11) begin
      bad++;
      $display("FAIL stall_release2: v=%b d=%b rd=%b want 1 %b 11", out_valid, out_data, out_rd, {D00_P, D00_P});
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_idle();
    logic [9:0] exp_c;
    apply_reset();
    idle_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      exp_c = (n % 2 == 0) ? K285_N : K285_P;
      total++;
      if (out_valid !== 1'b1 || out_data !== {exp_c, exp_c} || out_rd !== ((n % 2 == 0) ? 2'b11 : 2'b00) || out_k_err !== 2'b00) begin
        bad++;
        $display("FAIL idle_comma%0d: v=%b d=%b rd=%b ke=%b want 1 %b", n, out_valid, out_data, out_rd, out_k_err, {exp_c, exp_c});
      end
    end
    in_valid = 1'b1; in_k = 2'b00; in_data = 16'hB5B5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== {D215, D215} || out_rd !== 2'b00) begin
      bad++;
      $display("FAIL idle_insert_d215: v=%b d=%b rd=%b want 1 %b 00", out_valid, out_data, out_rd, {D215, D215});
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== {K285_N, K285_N} || out_rd !== 2'b11) begin
      bad++;
      $display("FAIL idle_resume: v=%b d=%b rd=%b want 1 %b 11", out_valid, out_data, out_rd, {K285_N, K285_N});
    end
    idle_en = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== {K285_N, K285_N}) begin
      bad++;
      $display("FAIL idle_off: v=%b d=%b want 0 %b", out_valid, out_data, {K285_N, K285_N});
    end
  endtask

  initial begin
    test_reset();
    test_d0();
    test_k28();
    test_kerr();
    test_stall();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
